forward_select_unit: RTL and testbench

- Control-side partner of the 9-to-1 EX operand forwarding mux: generates the 4-bit rs and rt select codes that the mux consumes.
- Keeps a shift-register scoreboard of in-flight producers across the eight forwardable stages: EX3..EX7, EX8 (SAD write value), MEM, WB.
- For each source operand of the instruction in the EX consumer stage, picks the youngest matching producer.
- Raises Stall when that producer's result is not yet valid.

---
 rtl/forward_select_unit.sv | 96 +++++++++
 tb/tb_forward_select_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/forward_select_unit.sv
// Operand-forwarding select generator: tracks in-flight producers across EX3..WB
// and derives the rs/rt select codes for the 9-to-1 EX forwarding mux, plus the stall.
module forward_select_unit #(
    parameter int REG_W     = 5,
    parameter int NUM_SLOTS = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Hold,
    input  logic             Issue_Valid,
    input  logic             Issue_RegWrite,
    input  logic [REG_W-1:0] Issue_Dest,
    input  logic [3:0]       Issue_Ready,
    input  logic [REG_W-1:0] Rs_Addr,
    input  logic [REG_W-1:0] Rt_Addr,
    input  logic             Uses_Rs,
    input  logic             Uses_Rt,
    output logic [3:0]       ALU_input_rs,
    output logic [3:0]       ALU_input_rt,
    output logic             Stall
);

    typedef struct packed {
        logic             v;
        logic             rw;
        logic [REG_W-1:0] dest;
        logic [3:0]       rdy;
    } slot_t;

    // Slot k holds the producer whose result appears on mux input k.
    slot_t      slot_q [1:NUM_SLOTS];
    slot_t      ins_d;
    logic [3:0] rs_sel;
    logic [3:0] rt_sel;
    logic       rs_req;
    logic       rt_req;
    logic       rs_hit;
    logic       rt_hit;

    always_comb begin
        ins_d.v    = Issue_Valid;
        ins_d.rw   = Issue_RegWrite;
        ins_d.dest = Issue_Dest;
        if (Issue_Ready == 4'd0)
            ins_d.rdy = 4'd1;
        else if (Issue_Ready > 4'd8)
            ins_d.rdy = 4'd8;
        else
            ins_d.rdy = Issue_Ready;
    end

    // Scan from youngest to oldest; the first hit decides the operand.
    always_comb begin
        rs_sel = 4'd0;
        rt_sel = 4'd0;
        rs_req = 1'b0;
        rt_req = 1'b0;
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int k = 1; k <= NUM_SLOTS; k++) begin
            if (!rs_hit && Uses_Rs && (Rs_Addr != '0) && slot_q[k].v && slot_q[k].rw
                && (slot_q[k].dest == Rs_Addr)) begin
                rs_hit = 1'b1;
                if (4'(k) >= slot_q[k].rdy)
                    rs_sel = 4'(k);
                else
                    rs_req = 1'b1;
            end
            if (!rt_hit && Uses_Rt && (Rt_Addr != '0) && slot_q[k].v && slot_q[k].rw
                && (slot_q[k].dest == Rt_Addr)) begin
                rt_hit = 1'b1;
                if (4'(k) >= slot_q[k].rdy)
                    rt_sel = 4'(k);
                else
                    rt_req = 1'b1;
            end
        end
    end

    assign Stall        = (rs_req | rt_req) & Issue_Valid;
    assign ALU_input_rs = Stall ? 4'd0 : rs_sel;
    assign ALU_input_rt = Stall ? 4'd0 : rt_sel;

    // A stalled consumer stays in EX, so a bubble enters slot 1 while older producers advance.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int k = 1; k <= NUM_SLOTS; k++)
                slot_q[k] <= '0;
        end else if (!Hold) begin
            for (int k = NUM_SLOTS; k >= 2; k--)
                slot_q[k] <= slot_q[k-1];
            slot_q[1] <= Stall ? '0 : ins_d;
        end
    end

endmodule

// File: tb/tb_forward_select_unit.sv
// Directed bench for forward_select_unit: stimulus queues expected selects/stall,
// a negedge monitor pops and compares them against the combinational outputs.
module tb_forward_select_unit;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       Hold;
    logic       Issue_Valid;
    logic       Issue_RegWrite;
    logic [4:0] Issue_Dest;
    logic [3:0] Issue_Ready;
    logic [4:0] Rs_Addr;
    logic [4:0] Rt_Addr;
    logic       Uses_Rs;
    logic       Uses_Rt;
    logic [3:0] ALU_input_rs;
    logic [3:0] ALU_input_rt;
    logic       Stall;

    typedef struct {
        string      name;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       st;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    forward_select_unit #(.REG_W(5), .NUM_SLOTS(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Hold(Hold),
        .Issue_Valid(Issue_Valid), .Issue_RegWrite(Issue_RegWrite),
        .Issue_Dest(Issue_Dest), .Issue_Ready(Issue_Ready),
        .Rs_Addr(Rs_Addr), .Rt_Addr(Rt_Addr), .Uses_Rs(Uses_Rs), .Uses_Rt(Uses_Rt),
        .ALU_input_rs(ALU_input_rs), .ALU_input_rt(ALU_input_rt), .Stall(Stall)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (ALU_input_rs !== e.rs) begin
                failures++;
                $display("FAIL %s rs: got %0d expected %0d", e.name, ALU_input_rs, e.rs);
            end
            checks++;
            if (ALU_input_rt !== e.rt) begin
                failures++;
                $display("FAIL %s rt: got %0d expected %0d", e.name, ALU_input_rt, e.rt);
            end
            checks++;
            if (Stall !== e.st) begin
                failures++;
                $display("FAIL %s stall: got %0b expected %0b", e.name, Stall, e.st);
            end
        end
    end

    // One cycle: drive at posedge+1, expectation checked at the following negedge.
    task automatic cyc(input logic rst_v, input logic hold_v, input logic iv, input logic irw,
                       input logic [4:0] idest, input logic [3:0] irdy,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic [3:0] ers, input logic [3:0] ert, input logic est, input string nm);
        exp_t e;
        Rst_n = rst_v; Hold = hold_v;
        Issue_Valid = iv; Issue_RegWrite = irw; Issue_Dest = idest; Issue_Ready = irdy;
        Rs_Addr = rs; Rt_Addr = rt; Uses_Rs = urs; Uses_Rt = urt;
        e.name = nm; e.rs = ers; e.rt = ert; e.st = est;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic ins(input logic [4:0] dest, input logic [3:0] rdy, input string nm);
        cyc(1, 0, 1, 1, dest, rdy, 0, 0, 0, 0, 0, 0, 0, nm);
    endtask

    task automatic fill(input string nm);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, nm);
    endtask

    initial begin
        Rst_n = 1'b0; Hold = 1'b0;
        Issue_Valid = 1'b0; Issue_RegWrite = 1'b0; Issue_Dest = '0; Issue_Ready = '0;
        Rs_Addr = '0; Rt_Addr = '0; Uses_Rs = 1'b0; Uses_Rt = 1'b0;
        @(posedge Clk);
        #1;
        cyc(0, 0, 1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, "rst_empty");

        // back-to-back forward from EX3 through WB
        ins(8, 1, "b2b_ins");
        for (int j = 1; j <= 8; j++)
            cyc(1, 0, 1, 0, 0, 0, 8, 0, 1, 0, 4'(j), 0, 0, $sformatf("b2b_slot%0d", j));
        cyc(1, 0, 1, 0, 0, 0, 8, 0, 1, 0, 0, 0, 0, "b2b_gone");

        // SAD latency: stalled consumer claims r13, forwarded one writes r12
        ins(10, 6, "sad_ins");
        for (int j = 1; j <= 5; j++)
            cyc(1, 0, 1, 1, 13, 1, 0, 10, 0, 1, 0, 0, 1, $sformatf("sad_stall%0d", j));
        cyc(1, 0, 1, 1, 12, 1, 0, 10, 0, 1, 0, 6, 0, "sad_fwd");
        cyc(1, 0, 1, 0, 0, 0, 13, 12, 1, 1, 0, 1, 0, "sad_bubble");

        // youngest wins: r3 in slots 5 and 2
        ins(3, 1, "yw_old");
        fill("yw_f1"); fill("yw_f2");
        ins(3, 1, "yw_young");
        fill("yw_f3");
        cyc(1, 0, 1, 0, 0, 0, 3, 3, 1, 1, 2, 2, 0, "yw_fwd");
        ins(3, 1, "yw2_old");
        fill("yw2_f1"); fill("yw2_f2");
        ins(3, 4, "yw2_young");
        fill("yw2_f3");
        cyc(1, 0, 1, 0, 0, 0, 3, 0, 1, 0, 0, 0, 1, "yw_stall");

        // register zero and unused operand
        ins(0, 1, "z_ins");
        cyc(1, 0, 1, 1, 7, 1, 0, 0, 1, 0, 0, 0, 0, "z_r0");
        cyc(1, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, "unused_rt");
        cyc(1, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 2, 0, "used_rt");

        // hold freezes a pending stall
        ins(4, 3, "h_ins");
        for (int j = 1; j <= 4; j++)
            cyc(1, 1, 1, 0, 0, 0, 4, 0, 1, 0, 0, 0, 1, $sformatf("h_frz%0d", j));
        cyc(1, 0, 1, 0, 0, 0, 4, 0, 1, 0, 0, 0, 1, "h_rel1");
        cyc(1, 0, 1, 0, 0, 0, 4, 0, 1, 0, 0, 0, 1, "h_rel2");
        cyc(1, 0, 1, 0, 0, 0, 4, 0, 1, 0, 3, 0, 0, "h_fwd");

        // Ready above 8 clamps to 8: seven stall cycles then WB forward
        ins(21, 15, "clamp_ins");
        for (int j = 1; j <= 7; j++)
            cyc(1, 0, 1, 0, 0, 0, 21, 0, 1, 0, 0, 0, 1, $sformatf("clamp_stall%0d", j));
        cyc(1, 0, 1, 0, 0, 0, 21, 0, 1, 0, 8, 0, 0, "clamp_fwd");

        // asynchronous reset with a full scoreboard of r5 producers
        for (int j = 1; j <= 8; j++)
            ins(5, 1, $sformatf("r5_ins%0d", j));
        cyc(1, 0, 1, 0, 0, 0, 5, 5, 1, 1, 1, 1, 0, "r5_fwd");
        cyc(0, 0, 1, 0, 0, 0, 5, 5, 1, 1, 0, 0, 0, "rst_mid");
        cyc(1, 0, 1, 0, 0, 0, 5, 5, 1, 1, 0, 0, 0, "rst_after");

        repeat (2) @(negedge Clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
